// File: rtl/keycode_sprite_mover.sv
// Keycode-driven sprite mover: frame-rate sampling of an HID keycode with an accelerate/cruise/idle motion FSM.
// Optional SPRITE_WRAP_EN: out-of-bound moves wrap to the opposite bound and bump stays low.
module keycode_sprite_mover #(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 623,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 463,
    parameter int X_INIT      = 312,
    parameter int Y_INIT      = 232,
    parameter int MAX_SPEED   = 4,
    parameter int SPRITE_BASE = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       vs,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [3:0] SpriteID,
    output logic       moving,
    output logic       bump
);
    // state  | meaning
    // IDLE   | no direction key on the last tick, speed 0
    // ACCEL  | speed ramping by 1 per tick toward MAX_SPEED
    // CRUISE | moving at MAX_SPEED in a steady direction
    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;

    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_RIGHT = 2'd3;
    localparam logic [3:0]  MAX_SPD   = 4'(MAX_SPEED);
    localparam logic [3:0]  BASE_ID   = 4'(SPRITE_BASE);
    localparam logic [10:0] X_LO      = 11'(X_MIN);
    localparam logic [10:0] X_HI      = 11'(X_MAX);
    localparam logic [10:0] Y_LO      = 11'(Y_MIN);
    localparam logic [10:0] Y_HI      = 11'(Y_MAX);

    logic vs_meta, vs_sync, vs_prev;
    logic [1:0] settle;
    logic armed;
    logic tick;

    // armed keeps a vs already low at reset release from looking like a falling edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
            settle  <= 2'd0;
            armed   <= 1'b0;
        end else begin
            vs_meta <= vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            if (settle != 2'd2) settle <= settle + 2'd1;
            armed   <= armed | ((settle == 2'd2) & vs_sync);
        end
    end

    assign tick = armed & vs_prev & ~vs_sync;

    state_t      state, state_n;
    logic [3:0]  speed, speed_n;
    logic [1:0]  dir, dir_n;
    logic [9:0]  pos_x, pos_x_n, pos_y, pos_y_n;
    logic [3:0]  sprite_id, sprite_id_n;
    logic        moving_q, moving_n;
    logic        bump_q, bump_n;

    logic        has_dir;
    logic [1:0]  key_dir;
    logic        do_move;
    logic [10:0] step, cur, lo, hi, moved, bound_res, res;
    logic        oob;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            speed     <= 4'd0;
            dir       <= DIR_DOWN;
            pos_x     <= 10'(X_INIT);
            pos_y     <= 10'(Y_INIT);
            sprite_id <= BASE_ID + 4'd1;
            moving_q  <= 1'b0;
            bump_q    <= 1'b0;
        end else begin
            state     <= state_n;
            speed     <= speed_n;
            dir       <= dir_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            sprite_id <= sprite_id_n;
            moving_q  <= moving_n;
            bump_q    <= bump_n;
        end
    end

    always_comb begin
        has_dir = 1'b1;
        key_dir = DIR_UP;
        case (keycode)
            8'h1A:   key_dir = DIR_UP;
            8'h16:   key_dir = DIR_DOWN;
            8'h04:   key_dir = DIR_LEFT;
            8'h07:   key_dir = DIR_RIGHT;
            default: has_dir = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        speed_n     = speed;
        dir_n       = dir;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        sprite_id_n = sprite_id;
        moving_n    = moving_q;
        bump_n      = 1'b0;
        do_move     = 1'b0;
        step        = 11'd0;
        cur         = 11'd0;
        lo          = 11'd0;
        hi          = 11'd0;
        moved       = 11'd0;
        bound_res   = 11'd0;
        res         = 11'd0;
        oob         = 1'b0;

        if (tick) begin
            if (!has_dir) begin
                state_n = IDLE;
                speed_n = 4'd0;
            end else if (state == IDLE || key_dir != dir) begin
                dir_n   = key_dir;
                speed_n = 4'd1;
                step    = 11'd1;
                do_move = 1'b1;
                state_n = (MAX_SPD == 4'd1) ? CRUISE : ACCEL;
            end else if (state == ACCEL) begin
                speed_n = speed + 4'd1;
                step    = {7'd0, speed + 4'd1};
                do_move = 1'b1;
                state_n = (speed + 4'd1 == MAX_SPD) ? CRUISE : ACCEL;
            end else begin
                step    = {7'd0, MAX_SPD};
                do_move = 1'b1;
            end
            moving_n    = (state_n != IDLE);
            sprite_id_n = BASE_ID + {2'b00, dir_n};
        end

        if (do_move) begin
            cur = dir_n[1] ? {1'b0, pos_x} : {1'b0, pos_y};
            lo  = dir_n[1] ? X_LO : Y_LO;
            hi  = dir_n[1] ? X_HI : Y_HI;
            // even dirs (up, left) decrease, odd dirs (down, right) increase
            if (dir_n[0]) begin
                moved = cur + step;
                oob   = (moved > hi);
`ifdef SPRITE_WRAP_EN
                bound_res = lo;
`else
                bound_res = hi;
`endif
            end else begin
                moved = cur - step;
                oob   = (cur < lo + step);
`ifdef SPRITE_WRAP_EN
                bound_res = hi;
`else
                bound_res = lo;
`endif
            end
            res = oob ? bound_res : moved;
            if (dir_n[1]) pos_x_n = res[9:0];
            else          pos_y_n = res[9:0];
`ifdef SPRITE_WRAP_EN
            bump_n = 1'b0;
`else
            bump_n = oob;
`endif
        end
    end

    assign PosX     = pos_x;
    assign PosY     = pos_y;
    assign SpriteID = sprite_id;
    assign moving   = moving_q;
    assign bump     = bump_q;

endmodule

// File: tb/tb_keycode_sprite_mover.sv
// Directed bench for keycode_sprite_mover: a default instance plus one with X_INIT=620 for the right-bound case.
module tb_keycode_sprite_mover;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00, keycode2 = 8'h00;
    logic       vs = 1'b1, vs2 = 1'b1;
    logic [9:0] PosX, PosY, PosX2, PosY2;
    logic [3:0] SpriteID, SpriteID2;
    logic       moving, bump, moving2, bump2;

    int errors = 0;
    int checks = 0;

    int cap_x, cap_y, cap_id, cap_mv, cap_bump, cap_bump_next;

    always #5 Clk = ~Clk;

    keycode_sprite_mover dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .vs(vs),
        .PosX(PosX), .PosY(PosY), .SpriteID(SpriteID), .moving(moving), .bump(bump)
    );

    keycode_sprite_mover #(.X_INIT(620)) dut2 (
        .Clk(Clk), .Reset(Reset), .keycode(keycode2), .vs(vs2),
        .PosX(PosX2), .PosY(PosY2), .SpriteID(SpriteID2), .moving(moving2), .bump(bump2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic capture(input int unit);
        if (unit == 0) begin
            cap_x = PosX; cap_y = PosY; cap_id = SpriteID; cap_mv = moving; cap_bump = bump;
        end else begin
            cap_x = PosX2; cap_y = PosY2; cap_id = SpriteID2; cap_mv = moving2; cap_bump = bump2;
        end
    endtask

    // vs falls, outputs sampled after the update edge and one cycle later, then vs returns high
    task automatic frame(input int unit);
        @(negedge Clk);
        if (unit == 0) vs = 1'b0; else vs2 = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        capture(unit);
        @(negedge Clk);
        cap_bump_next = (unit == 0) ? int'(bump) : int'(bump2);
        repeat (3) @(negedge Clk);
        if (unit == 0) vs = 1'b1; else vs2 = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    int exp_x2[5] = '{313, 315, 318, 322, 326};

    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check("reset_posx", PosX, 312);
        check("reset_posy", PosY, 232);
        check("reset_id", SpriteID, 5);
        check("reset_moving", moving, 0);
        check("reset_bump", bump, 0);

        keycode = 8'h07;
        for (int i = 0; i < 5; i++) begin
            frame(0);
            check($sformatf("right_x%0d", i), cap_x, exp_x2[i]);
            check($sformatf("right_id%0d", i), cap_id, 7);
            check($sformatf("right_mv%0d", i), cap_mv, 1);
            check($sformatf("right_bump%0d", i), cap_bump, 0);
        end

        keycode = 8'h04;
        frame(0);
        check("left_x0", cap_x, 325);
        check("left_id0", cap_id, 6);
        frame(0);
        check("left_x1", cap_x, 323);
        check("left_id1", cap_id, 6);
        check("left_y", cap_y, 232);

        keycode2 = 8'h07;
        frame(1);
        check("edge_x0", cap_x, 621);
        check("edge_bump0", cap_bump, 0);
        frame(1);
        check("edge_x1", cap_x, 623);
        check("edge_bump1", cap_bump, 0);
        frame(1);
`ifdef SPRITE_WRAP_EN
        check("edge_x2", cap_x, 0);
        check("edge_bump2", cap_bump, 0);
`else
        check("edge_x2", cap_x, 623);
        check("edge_bump2", cap_bump, 1);
`endif
        check("edge_bump_after", cap_bump_next, 0);
        check("edge_id", cap_id, 7);

        // long vs low: one tick, keycode churn afterwards must not move anything
        keycode = 8'h00;
        @(negedge Clk);
        vs = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("idle_mv_tick", moving, 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (i % 50 == 10) keycode = (keycode == 8'h07) ? 8'h1A : 8'h07;
        end
        check("idle_x", PosX, 323);
        check("idle_y", PosY, 232);
        check("idle_mv", moving, 0);
        check("idle_id", SpriteID, 6);
        keycode = 8'h00;
        vs = 1'b1;
        repeat (6) @(negedge Clk);
        keycode = 8'h16;
        repeat (5) @(negedge Clk);
        keycode = 8'h00;
        frame(0);
        check("idle2_x", cap_x, 323);
        check("idle2_y", cap_y, 232);
        check("idle2_mv", cap_mv, 0);

        // start ACCEL upward, then reset during the next tick cycle
        keycode = 8'h1A;
        frame(0);
        check("up_y0", cap_y, 231);
        check("up_id0", cap_id, 4);
        @(negedge Clk);
        vs = 1'b0;
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("arst_posx", PosX, 312);
        check("arst_posy", PosY, 232);
        check("arst_id", SpriteID, 5);
        check("arst_mv", moving, 0);
        check("arst_bump", bump, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("rel_low_y", PosY, 232);
        check("rel_low_mv", moving, 0);
        vs = 1'b1;
        repeat (6) @(negedge Clk);
        frame(0);
        check("post_rst_y", cap_y, 231);
        check("post_rst_id", cap_id, 4);
        check("post_rst_mv", cap_mv, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
